// File: rtl/fp16_pkg.sv
// fp16_pkg: constants and types shared by the FP16 arithmetic blocks. The
// multiplier and the sequential divider both use these.
//   BIAS / EXP_MAX / QNAN : half-precision format constants
//   FLAG_*                : bit positions in the 4-bit ALU flag vector
//   divState_e            : divider control states
//   makeFlags()           : builds the flag vector from its parts
package fp16_pkg;

  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;
  localparam logic [15:0] QNAN = 16'h7E00;

  localparam int FLAG_OVF   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PACK = 2'd2
  } divState_e;

  // Carry has no meaning for a divide, so it is always cleared here.
  function automatic logic [3:0] makeFlags(input logic ovf, input logic zero,
                                           input logic neg);
    logic [3:0] f;
    f             = '0;
    f[FLAG_OVF]   = ovf;
    f[FLAG_ZERO]  = zero;
    f[FLAG_CARRY] = 1'b0;
    f[FLAG_NEG]   = neg;
    return f;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// fp16_lzc: leading-zero counter for an 11-bit FP16 mantissa (hidden bit in
// bit 10). Purely combinational.
//   mant : 11-bit mantissa
//   lz   : number of zeros above the highest set bit (0..10), 11 if mant==0
module fp16_lzc (
  input  logic [10:0] mant,
  output logic [3:0]  lz
);

  // Scan upward from the LSB so that the highest set bit is the last one
  // to write lz.
  always_comb begin
    lz = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (mant[i]) lz = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fp16_div_seq.sv
// fp16_div_seq: multi-cycle IEEE-754 half-precision divider (a / b).
// A restoring divider produces one quotient bit per cycle. The result is
// truncated. Subnormal inputs are accepted. Subnormal results are flushed
// to zero.
//   clk    : system clock, rising edge
//   reset  : synchronous, active low
//   start  : request, sampled only while idle
//   a, b   : FP16 dividend / divisor
//   busy   : operation in flight (includes the done cycle)
//   done   : one-cycle pulse; div16/flags are valid from this cycle
//   div16  : {16'b0, FP16 quotient}, held until the next result
//   flags  : {overflow, zero, carry(0), negative}
//
// Handshake: a start is accepted on a rising edge where the FSM is IDLE,
// no done pulse is showing, and start==1. a/b are captured on that edge
// and ignored afterwards. Exactly one done pulse follows each accepted
// start, unless reset intervenes. The pulse comes 1 cycle after the accept
// edge for special operands and 13 cycles after it otherwise. A start that
// is high while busy is dropped, not queued.
module fp16_div_seq #(
  parameter int BIAS  = fp16_pkg::BIAS,
  parameter int QBITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] div16,
  output logic [3:0]  flags
);

  import fp16_pkg::*;

  localparam logic signed [7:0] BIAS_S    = BIAS[7:0];
  localparam logic signed [7:0] EXP_MAX_S = EXP_MAX[7:0];

  // The FSM state is a plain named signal so that checkers can bind to it.
  divState_e   state, nextState;
  logic        accept;

  // Registers captured at accept time.
  logic        signReg;
  logic        specReg;
  logic [15:0] specRes;
  logic [3:0]  specFlags;
  logic [10:0] mBReg;
  logic signed [7:0] expReg;

  // Divider state.
  logic [11:0] rem;
  logic [11:0] quo;
  logic [3:0]  cnt;

  // Output registers.
  logic        doneReg;
  logic [15:0] resReg;
  logic [3:0]  flagsReg;

  // ---------------- operand classification and normalization ----------------
  logic [4:0]  expA, expB;
  logic [10:0] mantA, mantB, normA, normB;
  logic [4:0]  rawA, rawB;
  logic [3:0]  lzA, lzB;
  logic signed [7:0] eA, eB, eNew;
  logic        sign;
  logic        isSpec;
  logic [15:0] specVal;
  logic [3:0]  specFl;

  assign expA  = a[14:10];
  assign expB  = b[14:10];
  assign mantA = {expA != 5'd0, a[9:0]};
  assign mantB = {expB != 5'd0, b[9:0]};
  // A subnormal carries the same scale as exponent 1.
  assign rawA  = (expA == 5'd0) ? 5'd1 : expA;
  assign rawB  = (expB == 5'd0) ? 5'd1 : expB;
  assign sign  = a[15] ^ b[15];

  fp16_lzc uLzcA (.mant(mantA), .lz(lzA));
  fp16_lzc uLzcB (.mant(mantB), .lz(lzB));

  assign normA = mantA << lzA;
  assign normB = mantB << lzB;
  assign eA    = $signed({3'b000, rawA}) - $signed({4'b0000, lzA});
  assign eB    = $signed({3'b000, rawB}) - $signed({4'b0000, lzB});
  assign eNew  = eA - eB + BIAS_S;

  // Special operands, in priority order. Inf/NaN inputs win over the zero
  // checks, so 0/NaN and Inf/0 both give a quiet NaN.
  always_comb begin
    isSpec  = 1'b1;
    specVal = QNAN;
    specFl  = makeFlags(1'b0, 1'b1, 1'b0);
    if (expA == 5'h1F || expB == 5'h1F) begin
      specVal = QNAN;
      specFl  = makeFlags(1'b0, 1'b1, 1'b0);
    end else if (b[14:0] == 15'd0 && a[14:0] == 15'd0) begin
      specVal = QNAN;
      specFl  = makeFlags(1'b0, 1'b1, 1'b0);
    end else if (b[14:0] == 15'd0) begin
      specVal = {sign, 5'h1F, 10'd0};
      specFl  = makeFlags(1'b1, 1'b0, sign);
    end else if (a[14:0] == 15'd0) begin
      specVal = {sign, 15'd0};
      specFl  = makeFlags(1'b0, 1'b1, sign);
    end else begin
      isSpec  = 1'b0;
    end
  end

  // ---------------- one restoring-division step ----------------
  // rem < 2*mB always holds, so the shifted remainder fits in 12 bits.
  logic        qBit;
  logic [11:0] remNext;

  assign qBit    = (rem >= {1'b0, mBReg});
  assign remNext = (qBit ? (rem - {1'b0, mBReg}) : rem) << 1;

  // ---------------- pack ----------------
  // Q is in [0x400, 0xFFF]. When bit 11 is clear, the quotient is below 1.0
  // and the exponent drops by one.
  logic signed [7:0] eAdj;
  logic [9:0]  frac;
  logic [15:0] packRes;
  logic [3:0]  packFl;

  always_comb begin
    eAdj    = quo[11] ? expReg : expReg - 8'sd1;
    frac    = quo[11] ? quo[10:1] : quo[9:0];
    packRes = {signReg, eAdj[4:0], frac};
    packFl  = makeFlags(1'b0, 1'b0, signReg);
    if (specReg) begin
      packRes = specRes;
      packFl  = specFlags;
    end else if (eAdj >= EXP_MAX_S) begin
      packRes = {signReg, 5'h1F, 10'd0};
      packFl  = makeFlags(1'b1, 1'b0, signReg);
    end else if (eAdj <= 8'sd0) begin
      packRes = {signReg, 15'd0};
      packFl  = makeFlags(1'b0, 1'b1, signReg);
    end
  end

  // ---------------- control ----------------
  // The done cycle counts as busy. The FSM does not accept a start in that
  // cycle, so the earliest restart is the cycle after done.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !doneReg) begin
          accept    = 1'b1;
          nextState = isSpec ? PACK : DIV;
        end
      end
      DIV: begin
        if (cnt == 4'(QBITS - 1)) nextState = PACK;
      end
      PACK: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      doneReg   <= 1'b0;
      resReg    <= '0;
      flagsReg  <= '0;
      signReg   <= 1'b0;
      specReg   <= 1'b0;
      specRes   <= '0;
      specFlags <= '0;
      mBReg     <= '0;
      expReg    <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
    end else begin
      state   <= nextState;
      doneReg <= (state == PACK);
      if (accept) begin
        signReg   <= sign;
        specReg   <= isSpec;
        specRes   <= specVal;
        specFlags <= specFl;
        mBReg     <= normB;
        expReg    <= eNew;
        rem       <= {1'b0, normA};
        quo       <= '0;
        cnt       <= '0;
      end
      if (state == DIV) begin
        rem <= remNext;
        quo <= {quo[10:0], qBit};
        cnt <= cnt + 4'd1;
      end
      if (state == PACK) begin
        resReg   <= packRes;
        flagsReg <= packFl;
      end
    end
  end

  assign busy  = (state != IDLE) || doneReg;
  assign done  = doneReg;
  assign div16 = {16'd0, resReg};
  assign flags = flagsReg;

endmodule
